// File: rtl/boot_seq_ctrl.sv
// Host command sequencer: parses LOAD/JUMP/RUN/STEP bytes from the UART and
// drives program-memory writes, PC load/increment strobes and core enable.
//
// Ports:
//   clk, reset        system clock, async active-high reset
//   rx_valid/rx_data  received byte strobe and data
//   exec_done         core retired one instruction
//   pc_load/_val      1-cycle PC load strobe and target
//   pc_inc            1-cycle PC increment strobe
//   mem_we/addr/wdata 1-cycle program memory write
//   core_en           core may execute
//   busy              a command is in progress
//   err               sticky error, cleared by the next accepted opcode
//
// Build option: BOOT_CHECKSUM_EN adds a trailing checksum byte to LOAD.
module boot_seq_ctrl #(
    parameter int AW        = 8,
    parameter int TO_W      = 20,
    parameter int TO_CYCLES = 500000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rx_valid,
    input  logic [7:0]    rx_data,
    input  logic          exec_done,
    output logic          pc_load,
    output logic [AW-1:0] pc_load_val,
    output logic          pc_inc,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    output logic          core_en,
    output logic          busy,
    output logic          err
);

    localparam logic [7:0] OP_LOAD = 8'hA5;
    localparam logic [7:0] OP_JUMP = 8'h5A;
    localparam logic [7:0] OP_RUN  = 8'h3C;
    localparam logic [7:0] OP_STEP = 8'hC3;
    localparam logic [7:0] OP_STOP = 8'h0F;

    localparam logic [TO_W-1:0] TO_LIM   = TO_W'(TO_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_ONE   = TO_W'(1);
    localparam logic [AW-1:0]   ADDR_ONE = AW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_ADDR,
        S_GET_LEN,
        S_LOAD_DATA,
        S_GET_JMP,
        S_RUN,
        S_STEP
`ifdef BOOT_CHECKSUM_EN
        ,
        S_GET_CS
`endif
    } state_t;

    state_t state, state_d;

    logic [AW-1:0]   base, base_d;
    logic [AW-1:0]   idx, idx_d;
    // Remaining data bytes; 9 bits so a length byte of 0 can mean 256.
    logic [8:0]      rem, rem_d;
    logic [TO_W-1:0] to_cnt, to_d;

    logic            pc_load_d;
    logic [AW-1:0]   pc_load_val_d;
    logic            pc_inc_d;
    logic            mem_we_d;
    logic [AW-1:0]   mem_addr_d;
    logic [7:0]      mem_wdata_d;
    logic            core_en_d;
    logic            err_d;
    logic            timed;

`ifdef BOOT_CHECKSUM_EN
    logic [7:0]      cs, cs_d;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            base        <= '0;
            idx         <= '0;
            rem         <= '0;
            to_cnt      <= '0;
            pc_load     <= 1'b0;
            pc_load_val <= '0;
            pc_inc      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            core_en     <= 1'b0;
            busy        <= 1'b0;
            err         <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
            cs          <= '0;
`endif
        end else begin
            base        <= base_d;
            idx         <= idx_d;
            rem         <= rem_d;
            to_cnt      <= to_d;
            pc_load     <= pc_load_d;
            pc_load_val <= pc_load_val_d;
            pc_inc      <= pc_inc_d;
            mem_we      <= mem_we_d;
            mem_addr    <= mem_addr_d;
            mem_wdata   <= mem_wdata_d;
            core_en     <= core_en_d;
            busy        <= (state_d != S_IDLE);
            err         <= err_d;
`ifdef BOOT_CHECKSUM_EN
            cs          <= cs_d;
`endif
        end
    end

    always_comb begin
        state_d       = state;
        base_d        = base;
        idx_d         = idx;
        rem_d         = rem;
        to_d          = '0;
        pc_load_d     = 1'b0;
        pc_load_val_d = pc_load_val;
        pc_inc_d      = 1'b0;
        mem_we_d      = 1'b0;
        mem_addr_d    = mem_addr;
        mem_wdata_d   = mem_wdata;
        core_en_d     = 1'b0;
        err_d         = err;
        timed         = 1'b0;
`ifdef BOOT_CHECKSUM_EN
        cs_d          = cs;
`endif

        unique case (state)
            S_IDLE: begin
                if (rx_valid) begin
                    unique case (rx_data)
                        OP_LOAD: begin
                            state_d = S_GET_ADDR;
                            err_d   = 1'b0;
                        end
                        OP_JUMP: begin
                            state_d = S_GET_JMP;
                            err_d   = 1'b0;
                        end
                        OP_RUN: begin
                            state_d   = S_RUN;
                            core_en_d = 1'b1;
                            err_d     = 1'b0;
                        end
                        OP_STEP: begin
                            state_d   = S_STEP;
                            core_en_d = 1'b1;
                            err_d     = 1'b0;
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            end

            S_GET_ADDR: begin
                timed = 1'b1;
                if (rx_valid) begin
                    base_d  = AW'(rx_data);
                    state_d = S_GET_LEN;
`ifdef BOOT_CHECKSUM_EN
                    cs_d    = rx_data;
`endif
                end
            end

            S_GET_LEN: begin
                timed = 1'b1;
                if (rx_valid) begin
                    rem_d   = (rx_data == 8'h00) ? 9'd256
                                                 : {1'b0, rx_data};
                    idx_d   = '0;
                    state_d = S_LOAD_DATA;
`ifdef BOOT_CHECKSUM_EN
                    cs_d    = cs + rx_data;
`endif
                end
            end

            S_LOAD_DATA: begin
                timed = 1'b1;
                if (rx_valid) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = base + idx;
                    mem_wdata_d = rx_data;
                    idx_d       = idx + ADDR_ONE;
                    rem_d       = rem - 9'd1;
`ifdef BOOT_CHECKSUM_EN
                    cs_d        = cs + rx_data;
                    if (rem == 9'd1) state_d = S_GET_CS;
`else
                    if (rem == 9'd1) state_d = S_IDLE;
`endif
                end
            end

`ifdef BOOT_CHECKSUM_EN
            S_GET_CS: begin
                timed = 1'b1;
                if (rx_valid) begin
                    err_d   = (rx_data != cs);
                    state_d = S_IDLE;
                end
            end
`endif

            S_GET_JMP: begin
                timed = 1'b1;
                if (rx_valid) begin
                    pc_load_d     = 1'b1;
                    pc_load_val_d = AW'(rx_data);
                    state_d       = S_IDLE;
                end
            end

            S_RUN: begin
                core_en_d = 1'b1;
                if (exec_done) pc_inc_d = 1'b1;
                if (rx_valid && rx_data == OP_STOP) begin
                    core_en_d = 1'b0;
                    state_d   = S_IDLE;
                end
            end

            S_STEP: begin
                core_en_d = 1'b1;
                if (exec_done) begin
                    pc_inc_d  = 1'b1;
                    core_en_d = 1'b0;
                    state_d   = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase

        // Inter-byte idle counter; only runs while a command awaits bytes.
        if (timed && !rx_valid) begin
            if (to_cnt == TO_LIM) begin
                err_d   = 1'b1;
                state_d = S_IDLE;
            end else begin
                to_d = to_cnt + TO_ONE;
            end
        end
    end

endmodule

// File: tb/tb_boot_seq_ctrl.sv
// Scoreboard bench for boot_seq_ctrl: expected writes, PC loads and PC
// increments are queued at stimulus time and popped as the DUT emits them.
module tb_boot_seq_ctrl;

    localparam int AW = 8;
    localparam int TO_W = 8;
    localparam int TO_CYCLES = 40;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data = '0;
    logic          exec_done = 1'b0;
    logic          pc_load;
    logic [AW-1:0] pc_load_val;
    logic          pc_inc;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic          core_en;
    logic          busy;
    logic          err;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [15:0] exp_wr[$];
    logic [7:0]  exp_ld[$];
    int          exp_inc[$];
    logic [7:0]  ld[$];

    boot_seq_ctrl #(
        .AW(AW), .TO_W(TO_W), .TO_CYCLES(TO_CYCLES)
    ) dut (
        .clk(clk), .reset(reset),
        .rx_valid(rx_valid), .rx_data(rx_data),
        .exec_done(exec_done),
        .pc_load(pc_load), .pc_load_val(pc_load_val),
        .pc_inc(pc_inc),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .core_en(core_en), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (mem_we) begin
                if (exp_wr.size() == 0) check("wr_extra", 1, 0);
                else check("wr", {mem_addr, mem_wdata}, exp_wr.pop_front());
            end
            if (pc_load) begin
                if (exp_ld.size() == 0) check("ld_extra", 1, 0);
                else check("ld_val", pc_load_val, exp_ld.pop_front());
            end
            if (pc_inc) begin
                if (exp_inc.size() == 0) check("inc_extra", 1, 0);
                else check("inc_cyc", cyc, exp_inc.pop_front());
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Back-to-back calls produce consecutive rx_valid cycles.
    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic pulse_exec();
        exp_inc.push_back(cyc + 1);
        exec_done = 1'b1;
        @(posedge clk);
        #1;
        exec_done = 1'b0;
    endtask

    task automatic do_load(input logic [7:0] base, input logic [7:0] len_b);
        int n;
        logic [7:0] cs;
        logic [7:0] a;
        n  = (len_b == 8'h00) ? 256 : int'(len_b);
        cs = base + len_b;
        send(8'hA5);
        send(base);
        send(len_b);
        for (int i = 0; i < n; i++) begin
            a  = base + 8'(i);
            cs = cs + ld[i];
            exp_wr.push_back({a, ld[i]});
            send(ld[i]);
        end
`ifdef BOOT_CHECKSUM_EN
        send(cs);
`endif
    endtask

    initial begin
        idle(3);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_core_en", core_en, 0);
        check("rst_strobes", {mem_we, pc_load, pc_inc}, 0);
        check("rst_vals", {mem_addr, mem_wdata, pc_load_val}, 0);
        reset = 1'b0;
        idle(2);

        ld = '{8'h11, 8'h22, 8'h33};
        do_load(8'h10, 8'h03);
        idle(2);
        check("t1_busy", busy, 0);
        check("t1_err", err, 0);

        ld = '{8'hAA, 8'hBB, 8'hCC};
        do_load(8'hFE, 8'h03);
        idle(2);
        check("t2_busy", busy, 0);

        ld.delete();
        for (int i = 0; i < 256; i++) ld.push_back(8'(i * 7 + 3));
        do_load(8'h80, 8'h00);
        idle(2);
        check("len256_busy", busy, 0);
        check("len256_err", err, 0);

        exp_ld.push_back(8'h40);
        send(8'h5A);
        send(8'h40);
        idle(2);
        check("t3_core_en", core_en, 0);
        check("t3_busy", busy, 0);

        send(8'h3C);
        check("run_core_en", core_en, 1);
        check("run_busy", busy, 1);
        pulse_exec();
        idle(2);
        pulse_exec();
        pulse_exec();
        send(8'h55);
        check("run_ign_err", err, 0);
        check("run_ign_en", core_en, 1);
        exp_inc.push_back(cyc + 1);
        exec_done = 1'b1;
        send(8'h0F);
        exec_done = 1'b0;
        idle(2);
        check("run_stop_en", core_en, 0);
        check("run_stop_busy", busy, 0);

        send(8'hC3);
        check("step_en", core_en, 1);
        idle(3);
        check("step_wait_en", core_en, 1);
        pulse_exec();
        idle(2);
        check("step_done_en", core_en, 0);
        check("step_busy", busy, 0);

        send(8'hA5);
        send(8'h10);
        idle(TO_CYCLES - 5);
        check("to_pre_busy", busy, 1);
        send(8'h03);
        idle(TO_CYCLES - 5);
        check("to_reload_busy", busy, 1);
        check("to_reload_err", err, 0);
        idle(10);
        check("to_err", err, 1);
        check("to_busy", busy, 0);
        send(8'h3C);
        check("to_clr_err", err, 0);
        check("to_run_en", core_en, 1);
        send(8'h0F);
        send(8'h77);
        check("bad_op_err", err, 1);

        exp_wr.push_back({8'h30, 8'h01});
        send(8'hA5);
        send(8'h30);
        send(8'h02);
        send(8'h01);
        idle(1);
        reset = 1'b1;
        idle(1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_we", mem_we, 0);
        reset = 1'b0;
        idle(1);
        send(8'h02);
        check("mid_rst_err", err, 1);
        idle(2);
        check("mid_rst_idle", busy, 0);

`ifdef BOOT_CHECKSUM_EN
        ld = '{8'h05};
        do_load(8'h00, 8'h01);
        idle(2);
        check("cs_ok_err", err, 0);
        exp_wr.push_back({8'h00, 8'h05});
        send(8'hA5);
        send(8'h00);
        send(8'h01);
        send(8'h05);
        send(8'h07);
        idle(2);
        check("cs_bad_err", err, 1);
        check("cs_bad_busy", busy, 0);
`endif

        idle(5);
        check("q_wr_left", exp_wr.size(), 0);
        check("q_ld_left", exp_ld.size(), 0);
        check("q_inc_left", exp_inc.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
